sr_lifo: RTL and testbench



---
 rtl/sr_lifo_pkg.sv | 25 ++
 rtl/sr_lifo_mem.sv | 32 +++
 rtl/sr_lifo.sv | 111 +++++++++++
 tb/tb_sr_lifo.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sr_lifo_pkg.sv
// Shared definitions for the schoolRISCV hardware stack: ISA encodings,
// default depth and the per-cycle operation decode.
package sr_lifo_pkg;

  // Custom-0 opcode space carries the stack instructions.
  localparam logic [6:0] RVOP_PUSH = 7'b0001011;
  localparam logic [2:0] RVF3_PUSH = 3'b000;
  localparam logic [6:0] RVOP_POP  = 7'b0001011;
  localparam logic [2:0] RVF3_POP  = 3'b001;

  localparam int LIFO_DEPTH_DEFAULT = 8;

  // Encoding matches {push,pop} so the decode is a plain cast.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } lifo_op_e;

  function automatic lifo_op_e lifo_op(input logic push, input logic pop);
    return lifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/sr_lifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module sr_lifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next array contents: single-entry update on write enable.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage register, no reset by design.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sr_lifo.sv
// Hardware stack for lifo.push / lifo.pop. Top-of-stack is presented
// combinationally so a pop result can be written back in the same cycle.
module sr_lifo
  import sr_lifo_pkg::*;
#(
  parameter int DEPTH = LIFO_DEPTH_DEFAULT,
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [CNTW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [CNTW-1:0]  peak,
  input  logic             errClr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  logic [CNTW-1:0]  count_q, count_d;
  logic [CNTW-1:0]  peak_q, peak_d, peak_base;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             ovf_ev, udf_ev;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, top_addr;
  logic [WIDTH-1:0] rd_data;
  lifo_op_e         op;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  // With count==0 this wraps to the last entry; the empty mux hides it.
  assign top_addr = AW'(count_q - 1'b1);

  sr_lifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (pushData),
    .raddr (top_addr),
    .rdata (rd_data)
  );

  // Operation decode: write port control, next count, error events,
  // sticky flags and high-watermark.
  always_comb begin
    op      = lifo_op(push, pop);
    wr_en   = 1'b0;
    wr_addr = count_q[AW-1:0];
    count_d = count_q;
    ovf_ev  = 1'b0;
    udf_ev  = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (full) ovf_ev = 1'b1;
        else begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      OP_POP: begin
        if (empty) udf_ev = 1'b1;
        else       count_d = count_q - 1'b1;
      end
      OP_REPL: begin
        // Simultaneous push+pop: overwrite top, or plain push when empty.
        wr_en = 1'b1;
        if (empty) count_d = CNTW'(1);
        else       wr_addr = top_addr;
      end
      default: ;
    endcase
    // Reset cycle must not disturb storage either.
    if (rst) wr_en = 1'b0;

    // A new event in the clear cycle still sets the flag.
    ovf_d     = (ovf_q & ~errClr) | ovf_ev;
    udf_d     = (udf_q & ~errClr) | udf_ev;
    peak_base = errClr ? '0 : peak_q;
    peak_d    = (count_d > peak_base) ? count_d : peak_base;
  end

  // State registers with synchronous reset overriding all strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      peak_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      peak_q  <= peak_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign popData   = empty ? '0 : rd_data;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign peak      = peak_q;

endmodule

// File: tb/tb_sr_lifo.sv
// Self-checking bench for sr_lifo: directed scenarios plus random traffic
// compared against a queue-based stack model.
module tb_sr_lifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst, push, pop, errClr;
  logic [WIDTH-1:0] pushData;
  logic [WIDTH-1:0] popData;
  logic [CNTW-1:0]  count, peak;
  logic             empty, full, overflow, underflow;

  sr_lifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .push(push), .pushData(pushData), .pop(pop),
    .popData(popData), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .peak(peak), .errClr(errClr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  logic [31:0] stk[$];
  bit          m_ovf, m_udf;
  int          m_peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_state();
    logic [31:0] top;
    top = 32'h0;
    if (stk.size() > 0) top = stk[stk.size()-1];
    chk("popData",   popData,           top);
    chk("count",     32'(count),        32'(stk.size()));
    chk("empty",     32'(empty),        32'(stk.size() == 0));
    chk("full",      32'(full),         32'(stk.size() == DEPTH));
    chk("overflow",  32'(overflow),     32'(m_ovf));
    chk("underflow", 32'(underflow),    32'(m_udf));
    chk("peak",      32'(peak),         32'(m_peak));
  endtask

  // Apply one cycle: drive at negedge, check pre-edge outputs, then
  // advance the model across the rising edge.
  task automatic step(input bit pu, input bit po, input logic [31:0] d,
                      input bit clr, input bit r);
    bit ovf_ev, udf_ev;
    @(negedge clk);
    push = pu; pop = po; pushData = d; errClr = clr; rst = r;
    #1 check_state();
    @(posedge clk);
    ovf_ev = 0; udf_ev = 0;
    if (r) begin
      stk.delete(); m_ovf = 0; m_udf = 0; m_peak = 0;
    end else begin
      if (pu && po) begin
        if (stk.size() > 0) stk[stk.size()-1] = d;
        else stk.push_back(d);
      end else if (pu) begin
        if (stk.size() < DEPTH) stk.push_back(d);
        else ovf_ev = 1;
      end else if (po) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else udf_ev = 1;
      end
      if (clr) begin m_ovf = 0; m_udf = 0; m_peak = 0; end
      m_ovf = m_ovf | ovf_ev;
      m_udf = m_udf | udf_ev;
      if (stk.size() > m_peak) m_peak = stk.size();
    end
  endtask

  initial begin
    push = 0; pop = 0; pushData = '0; errClr = 0; rst = 1;
    repeat (2) @(posedge clk);
    stk.delete(); m_ovf = 0; m_udf = 0; m_peak = 0;

    // Reset state held over idle cycles.
    repeat (3) step(0, 0, 0, 0, 0);

    // Basic LIFO ordering.
    step(1, 0, 32'h11, 0, 0);
    step(1, 0, 32'h22, 0, 0);
    step(1, 0, 32'h33, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("peak_after_3", 32'(peak), 32'd3);

    // Fill past capacity.
    for (int i = 1; i <= 9; i++) step(1, 0, 32'(i), 0, 0);
    #1;
    chk("full_const",  32'(full),     32'd1);
    chk("ovf_const",   32'(overflow), 32'd1);
    chk("cnt_const",   32'(count),    32'd8);
    chk("top_const",   popData,       32'd8);
    step(0, 1, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0, 0);

    // Underflow, then clear.
    step(0, 1, 0, 0, 0);
    #1 chk("udf_const", 32'(underflow), 32'd1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // Clear coinciding with a new error keeps the flag set.
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Replace-top and empty push+pop.
    step(1, 0, 32'hA, 0, 0);
    step(1, 1, 32'hB, 0, 0);
    step(0, 0, 0, 0, 0);
    #1 chk("repl_const", popData, 32'hB);
    step(0, 1, 0, 0, 0);
    step(1, 1, 32'hC, 0, 0);
    step(0, 0, 0, 0, 0);

    // Reset coinciding with push.
    step(1, 0, 32'h5, 0, 0);
    step(1, 0, 32'h5, 0, 0);
    step(1, 0, 32'h6, 0, 1);
    step(0, 0, 0, 0, 0);
    #1 chk("rst_cnt_const", 32'(count), 32'd0);

    // Random traffic with alternating push-heavy / pop-heavy phases.
    for (int i = 0; i < 800; i++) begin
      bit pu, po, clr, r;
      if ((i / 100) % 2 == 0) begin
        pu = ($urandom_range(0, 99) < 70);
        po = ($urandom_range(0, 99) < 35);
      end else begin
        pu = ($urandom_range(0, 99) < 30);
        po = ($urandom_range(0, 99) < 70);
      end
      clr = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 79) == 0);
      step(pu, po, $urandom, clr, r);
    end
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
